// File: rtl/task_pulse_sequencer_pkg.sv
// Shared types and default widths for the task pulse sequencer.
package task_pulse_sequencer_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned REP_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PULSE = 3'd2,
    ST_SPACE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/task_down_counter.sv
// Loadable down-counter shared by the delay, width and gap phases; expires at zero.
module task_down_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired_c
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/task_pulse_sequencer.sv
// Destination-domain task executor: delay, then a train of pulses, then a one-cycle TASK_DONE.
module task_pulse_sequencer
  import task_pulse_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned REP_WIDTH = REP_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CNT_WIDTH-1:0] DELAY,
  input  logic [CNT_WIDTH-1:0] WIDTH,
  input  logic [CNT_WIDTH-1:0] GAP,
  input  logic [REP_WIDTH-1:0] REPEAT,
  output logic                 PULSE_OUT,
  output logic                 BUSY,
  output logic                 TASK_DONE,
  output logic                 ABORTED
);

  state_e               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] width_q, gap_q;
  logic [REP_WIDTH-1:0] rep_q, pulse_cnt_q;
  logic                 cnt_load, cnt_exp, abort_nxt, start_acc, pulse_inc;
  logic [CNT_WIDTH-1:0] cnt_val;

  // A zero width still produces a one-cycle pulse.
  function automatic logic [CNT_WIDTH-1:0] width_m1(input logic [CNT_WIDTH-1:0] w);
    return (w == '0) ? '0 : w - CNT_WIDTH'(1);
  endfunction

  task_down_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired_c(cnt_exp)
  );

  always_comb begin
    state_nxt = state_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    abort_nxt = 1'b0;
    start_acc = 1'b0;
    pulse_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          start_acc = 1'b1;
          if (REPEAT == '0) begin
            state_nxt = ST_DONE;
          end else if (DELAY != '0) begin
            state_nxt = ST_WAIT;
            cnt_load  = 1'b1;
            cnt_val   = DELAY - CNT_WIDTH'(1);
          end else begin
            state_nxt = ST_PULSE;
            cnt_load  = 1'b1;
            cnt_val   = width_m1(WIDTH);
          end
        end
      end
      ST_WAIT, ST_SPACE: begin
        if (ABORT) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (cnt_exp) begin
          state_nxt = ST_PULSE;
          cnt_load  = 1'b1;
          cnt_val   = width_m1(width_q);
        end
      end
      ST_PULSE: begin
        if (ABORT) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (cnt_exp) begin
          pulse_inc = 1'b1;
          if (pulse_cnt_q == rep_q - REP_WIDTH'(1)) begin
            state_nxt = ST_DONE;
          end else if (gap_q != '0) begin
            state_nxt = ST_SPACE;
            cnt_load  = 1'b1;
            cnt_val   = gap_q - CNT_WIDTH'(1);
          end else begin
            cnt_load  = 1'b1;
            cnt_val   = width_m1(width_q);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      pulse_cnt_q <= '0;
      PULSE_OUT   <= 1'b0;
      BUSY        <= 1'b0;
      TASK_DONE   <= 1'b0;
      ABORTED     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (start_acc) begin
        width_q     <= WIDTH;
        gap_q       <= GAP;
        rep_q       <= REPEAT;
        pulse_cnt_q <= '0;
      end else if (pulse_inc) begin
        pulse_cnt_q <= pulse_cnt_q + REP_WIDTH'(1);
      end
      PULSE_OUT <= (state_nxt == ST_PULSE);
      BUSY      <= (state_nxt != ST_IDLE);
      TASK_DONE <= (state_nxt == ST_DONE);
      ABORTED   <= abort_nxt;
    end
  end

endmodule
